elevator_ctrl_n: RTL and testbench
==================================

# elevator_ctrl_n

Parametrised cabin controller for an N-floor single-cabin elevator and the successor to the fixed 4-floor state controller. It takes the merged effective request vector and drives the door and motor commands plus the one-hot cabin position. Unlike the previous generation, it derives travel direction internally using collective/SCAN scheduling and times door-open and floor-to-floor travel with internal counters, so no external `ud_mode`, `endRun` or `endOpen` is needed. It also emits a served-request clear pulse so the request latch sits directly above it.

## Interface
- `FLOORS`, default 4: number of floors; minimum 2.
- `RUN_TICKS`, default 32: cycles of travel per floor; minimum 1.
- `OPEN_TICKS`, default 64: cycles the door stays open; minimum 1.
- `clk` input, 1 bit: single clock; all logic on posedge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `enable` input, 1 bit: master switch; 0 forces the parked state.
- `req` input, `FLOORS` bits: effective requests, one bit per floor; bit 0 is the bottom floor.
- `door_hold` input, 1 bit: door-open button; restarts the open timer while the door is open.
- `position` output, `FLOORS` bits: one-hot cabin floor.
- `dir` output, 1 bit: 1 = up, 0 = down.
- `opendoor` output, 1 bit: door open command.
- `mv2nxt` output, 1 bit: motor command, move one floor in `dir`.
- `req_clr` output, `FLOORS` bits: one-cycle pulse, one-hot, clears the served floor's request.
- `state` output, 2 bits: `OFF`=0, `PAUSE`=1, `OPEN`=2, `MOVE`=3.

## Operation
- Reset values: `state`=`OFF`, `position`=1 (floor 0), `dir`=1, `opendoor`=0, `mv2nxt`=0, `req_clr`=0, timer=0.
- `enable`=0 while `rst`=0 gives identical behaviour to reset. This applies in every state and aborts an open or a move mid-way.
- `OFF`: with `enable`=1, go to `PAUSE`.
- `PAUSE`: evaluate the following in priority order.
  - `here` = `req` & `position` is nonzero: go to `OPEN`, set `opendoor`=1, pulse `req_clr`=`position`, load timer with `OPEN_TICKS`.
  - A request exists strictly ahead in `dir`: go to `MOVE`, set `mv2nxt`=1, load timer with `RUN_TICKS`.
  - A request exists only behind: toggle `dir`, then go to `MOVE` in the same cycle using the new direction.
  - No requests: stay in `PAUSE` with `dir` held.
- `OPEN`: decrement the timer each cycle.
  - `door_hold`=1 reloads the timer with `OPEN_TICKS`.
  - A new request at the current floor reloads the timer and pulses `req_clr` again.
  - Timer reaching 0 (after its last decrement): go to `PAUSE`, set `opendoor`=0.
- `MOVE`: decrement the timer each cycle.
  - At expiry: shift `position` one floor in `dir`, set `mv2nxt`=0, go to `PAUSE`.
  - Requests are ignored in transit; the cabin never stops between floors.
- Direction is never toggled while in `MOVE` or `OPEN`.
- Boundary rule: scheduling never commands up from the top floor or down from the bottom floor. A shift that would leave the one-hot range is a design error and is covered by an assertion.
- "Ahead up" means any `req` bit with index above the position index; "ahead down" means any bit with index below it.

## Timing
- All outputs are registered. A decision made in a state appears on the next edge.
- Door timing: `opendoor` is high for exactly `OPEN_TICKS` consecutive cycles when no hold or re-request occurs.
- Travel timing: `mv2nxt` is high for exactly `RUN_TICKS` cycles per floor. `position` updates on the same edge that `mv2nxt` falls.
- `req_clr` is high for exactly 1 cycle per service event. The upstream latch clears on that edge; `req` may still show the bit in the following cycle, and the block tolerates this because it is already in `OPEN`.
- Minimum `PAUSE` dwell is 1 cycle between `OPEN` and `MOVE`, and between `MOVE` and `OPEN`.
- Simultaneous `door_hold` and timer expiry: the hold wins and the door stays open.
- Counter width is `$clog2(max(RUN_TICKS, OPEN_TICKS)+1)`; the counter never wraps.

## Structure
- Package `elev_pkg` contains the `state_t` enum (`OFF`, `PAUSE`, `OPEN`, `MOVE`), the `DIR_UP`/`DIR_DN` constants, and a `floor_mask_above`/`floor_mask_below` function pair.
- Sub-module `elev_tick_timer` is a loadable down-counter with `load`, `load_val` and `expired` ports. A single instance is shared between the `OPEN` and `MOVE` states.
- The FSM, direction logic and `position` register live in `elevator_ctrl_n`.

## Test plan
All scenarios use `FLOORS`=4, `RUN_TICKS`=4, `OPEN_TICKS`=3.
- Reset, then `enable`=1 with `req`=0100: `MOVE` twice with 4-cycle `mv2nxt` pulses, `position` goes 0001→0010→0100, `req_clr`=0100 for one cycle, then `opendoor` high for 3 cycles.
- Cabin at 0100 with `dir`=up and `req`=0001: `dir` toggles to 0 in `PAUSE`, cabin descends to 0001 and the door opens there; `position` never exceeds 1000.
- `door_hold` pulsed on the 2nd open cycle: `opendoor` total high time is 2+3=5 cycles.
- Cabin at 0010 moving up with `req`=0001|1000: cabin serves 1000 first, then reverses and serves 0001.
- `enable` dropped mid-`MOVE`: next edge gives `state`=`OFF`, `position`=0001, `mv2nxt`=0, `opendoor`=0.
- `rst`=1 during `OPEN`: all outputs return to their reset values on the next edge, and `req_clr` stays 0.

Source files
------------

// File: rtl/elev_pkg.sv
// elev_pkg: shared types, constants and floor-mask helpers for the
// N-floor elevator cabin controller.
//   state_t            : cabin controller states (OFF/PAUSE/OPEN/MOVE)
//   DIR_UP / DIR_DN    : encodings of the dir output
//   MAX_FLOORS         : widest floor vector the mask helpers handle
//   floor_mask_above() : bits strictly above a one-hot position
//   floor_mask_below() : bits strictly below a one-hot position
package elev_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    PAUSE = 2'd1,
    OPEN  = 2'd2,
    MOVE  = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Floor vectors are zero-extended to this width before masking, so the
  // helpers stay independent of the FLOORS parameter of each instance.
  localparam int MAX_FLOORS = 32;

  typedef logic [MAX_FLOORS-1:0] fmask_t;

  localparam fmask_t FMASK_ONE = {{(MAX_FLOORS-1){1'b0}}, 1'b1};

  // For a one-hot pos, pos-1 is every bit below it; complementing that and
  // pos itself leaves every bit above it.
  function automatic fmask_t floor_mask_above(input fmask_t pos);
    return ~(pos | (pos - FMASK_ONE));
  endfunction

  function automatic fmask_t floor_mask_below(input fmask_t pos);
    return pos - FMASK_ONE;
  endfunction

endpackage

// File: rtl/elev_ctrl_chk.sv
// elev_ctrl_chk: property checker for elevator_ctrl_n.
//   clk, rst  : clock and synchronous reset of the controller
//   state     : controller state output
//   position  : one-hot cabin floor
//   dir       : travel direction (1 = up)
//   mv2nxt    : motor command
//   opendoor  : door command
module elev_ctrl_chk
  import elev_pkg::*;
#(
  parameter int FLOORS = 4
) (
  input logic              clk,
  input logic              rst,
  input logic [1:0]        state,
  input logic [FLOORS-1:0] position,
  input logic              dir,
  input logic              mv2nxt,
  input logic              opendoor
);

  a_pos_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(position));

  a_no_up_from_top: assert property (@(posedge clk) disable iff (rst)
    (mv2nxt && (dir == DIR_UP)) |-> !position[FLOORS-1]);

  a_no_dn_from_bottom: assert property (@(posedge clk) disable iff (rst)
    (mv2nxt && (dir == DIR_DN)) |-> !position[0]);

  a_door_motor_excl: assert property (@(posedge clk) disable iff (rst)
    !(mv2nxt && opendoor));

  a_move_matches_state: assert property (@(posedge clk) disable iff (rst)
    (state == 2'(MOVE)) == mv2nxt);

endmodule

// File: rtl/elev_tick_timer.sv
// elev_tick_timer: loadable down-counter shared by the door-open and
// floor-to-floor travel phases.
//   clk      : clock
//   rst      : synchronous active-high clear (count to 0)
//   load     : load load_val this cycle (wins over the decrement)
//   load_val : value to load
//   expired  : high while the count is 1, i.e. during the last cycle of
//              the loaded interval; the count then reaches 0 and holds
module elev_tick_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load, else decrement while nonzero, else hold at 0.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == W'(1));

endmodule

// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: single-cabin controller for an N-floor elevator with
// collective (SCAN) scheduling and internal door/travel timing.
// FLOORS must lie in 2..MAX_FLOORS (32).
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-high reset
//   enable    : 0 forces the parked (reset) state
//   req       : effective requests, bit 0 = bottom floor
//   door_hold : restarts the open timer while the door is open
//   position  : one-hot cabin floor
//   dir       : 1 = up, 0 = down
//   opendoor  : door open command
//   mv2nxt    : move one floor in dir
//   req_clr   : one-cycle one-hot pulse clearing the served request
//   state     : OFF=0, PAUSE=1, OPEN=2, MOVE=3
module elevator_ctrl_n
  import elev_pkg::*;
#(
  parameter int FLOORS     = 4,
  parameter int RUN_TICKS  = 32,
  parameter int OPEN_TICKS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [FLOORS-1:0] req,
  input  logic              door_hold,
  output logic [FLOORS-1:0] position,
  output logic              dir,
  output logic              opendoor,
  output logic              mv2nxt,
  output logic [FLOORS-1:0] req_clr,
  output logic [1:0]        state
);

  localparam int MAX_TICKS = (RUN_TICKS > OPEN_TICKS) ? RUN_TICKS : OPEN_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [FLOORS-1:0] POS_RESET = {{(FLOORS-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [FLOORS-1:0] position_q, position_d;
  logic              dir_q, dir_d;
  logic              opendoor_q, opendoor_d;
  logic              mv2nxt_q, mv2nxt_d;
  logic [FLOORS-1:0] req_clr_q, req_clr_d;

  fmask_t            pos_ext_s;
  fmask_t            req_ext_s;
  logic              any_above_s;
  logic              any_below_s;
  logic              ahead_s;
  logic              behind_s;
  logic              here_s;
  logic              rereq_s;
  logic              serve_s;
  logic              tmr_load_s;
  logic [CNT_W-1:0]  tmr_val_s;
  logic              tmr_rst_s;
  logic              tmr_expired_s;

  // Zero-extend position/requests and find pending calls above and below.
  always_comb begin
    pos_ext_s = '0;
    req_ext_s = '0;
    pos_ext_s[FLOORS-1:0] = position_q;
    req_ext_s[FLOORS-1:0] = req;
    any_above_s = |(req_ext_s & floor_mask_above(pos_ext_s));
    any_below_s = |(req_ext_s & floor_mask_below(pos_ext_s));
  end

  assign ahead_s  = (dir_q == DIR_UP) ? any_above_s : any_below_s;
  assign behind_s = (dir_q == DIR_UP) ? any_below_s : any_above_s;
  assign here_s   = |(req & position_q);
  // While req_clr is still high the upstream latch has not cleared yet, so
  // a request seen at this floor is the one just served, not a new one.
  assign rereq_s  = here_s && !(|req_clr_q);

  assign tmr_rst_s = rst || !enable;

  elev_tick_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (tmr_rst_s),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .expired  (tmr_expired_s)
  );

  // Next-state, direction, position and timer control.
  always_comb begin
    state_d    = state_q;
    position_d = position_q;
    dir_d      = dir_q;
    serve_s    = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    if (!enable) begin
      state_d    = OFF;
      position_d = POS_RESET;
      dir_d      = DIR_UP;
    end else begin
      case (state_q)
        OFF: begin
          state_d = PAUSE;
        end
        PAUSE: begin
          if (here_s) begin
            state_d    = OPEN;
            serve_s    = 1'b1;
            tmr_load_s = 1'b1;
            tmr_val_s  = CNT_W'(OPEN_TICKS);
          end else if (ahead_s) begin
            state_d    = MOVE;
            tmr_load_s = 1'b1;
            tmr_val_s  = CNT_W'(RUN_TICKS);
          end else if (behind_s) begin
            // Reverse and depart in the same decision.
            dir_d      = ~dir_q;
            state_d    = MOVE;
            tmr_load_s = 1'b1;
            tmr_val_s  = CNT_W'(RUN_TICKS);
          end else begin
            state_d = PAUSE;
          end
        end
        OPEN: begin
          // A hold or re-request beats expiry, keeping the door open.
          if (door_hold || rereq_s) begin
            state_d    = OPEN;
            serve_s    = rereq_s;
            tmr_load_s = 1'b1;
            tmr_val_s  = CNT_W'(OPEN_TICKS);
          end else if (tmr_expired_s) begin
            state_d = PAUSE;
          end else begin
            state_d = OPEN;
          end
        end
        MOVE: begin
          if (tmr_expired_s) begin
            state_d = PAUSE;
            if (dir_q == DIR_UP) begin
              position_d = {position_q[FLOORS-2:0], 1'b0};
            end else begin
              position_d = {1'b0, position_q[FLOORS-1:1]};
            end
          end else begin
            state_d = MOVE;
          end
        end
        default: begin
          state_d = OFF;
        end
      endcase
    end
  end

  // Output commands follow the state being entered, so they are registered
  // alongside it.
  always_comb begin
    opendoor_d = (state_d == OPEN);
    mv2nxt_d   = (state_d == MOVE);
    if (serve_s) begin
      req_clr_d = position_q;
    end else begin
      req_clr_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      position_q <= POS_RESET;
      dir_q      <= DIR_UP;
      opendoor_q <= 1'b0;
      mv2nxt_q   <= 1'b0;
      req_clr_q  <= '0;
    end else begin
      state_q    <= state_d;
      position_q <= position_d;
      dir_q      <= dir_d;
      opendoor_q <= opendoor_d;
      mv2nxt_q   <= mv2nxt_d;
      req_clr_q  <= req_clr_d;
    end
  end

  assign position = position_q;
  assign dir      = dir_q;
  assign opendoor = opendoor_q;
  assign mv2nxt   = mv2nxt_q;
  assign req_clr  = req_clr_q;
  assign state    = state_q;

  elev_ctrl_chk #(
    .FLOORS (FLOORS)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .state    (state_q),
    .position (position_q),
    .dir      (dir_q),
    .mv2nxt   (mv2nxt_q),
    .opendoor (opendoor_q)
  );

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: directed scenarios plus randomized traffic for
// elevator_ctrl_n, checked every cycle against a floor-index reference
// model. The bench also plays the upstream request latch.
module tb_elevator_ctrl_n;

  localparam int NF     = 4;
  localparam int RUN_T  = 4;
  localparam int OPEN_T = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [NF-1:0] req = '0;
  logic          door_hold = 1'b0;
  logic [NF-1:0] position;
  logic          dir;
  logic          opendoor;
  logic          mv2nxt;
  logic [NF-1:0] req_clr;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  // Reference model: spec state number, floor index, direction,
  // remaining cycles of the current open/run interval, floor being cleared.
  int m_st    = 0;
  int m_floor = 0;
  bit m_dir   = 1'b1;
  int m_left  = 0;
  int m_clr   = -1;

  // Observed activity counters for directed scenarios.
  int open_cnt = 0;
  int mv_cnt   = 0;
  int clr_cnt  = 0;
  int clr_seq[$];

  elevator_ctrl_n #(
    .FLOORS     (NF),
    .RUN_TICKS  (RUN_T),
    .OPEN_TICKS (OPEN_T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .door_hold (door_hold),
    .position  (position),
    .dir       (dir),
    .opendoor  (opendoor),
    .mv2nxt    (mv2nxt),
    .req_clr   (req_clr),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference model, from the inputs seen at the edge.
  task automatic model_step();
    int  clr_now;
    bit  up_pending;
    bit  dn_pending;
    bit  fresh;
    clr_now = m_clr;
    m_clr   = -1;
    up_pending = 1'b0;
    dn_pending = 1'b0;
    for (int f = 0; f < NF; f++) begin
      if (req[f] && f > m_floor) up_pending = 1'b1;
      if (req[f] && f < m_floor) dn_pending = 1'b1;
    end
    if (rst || !enable) begin
      m_st = 0; m_floor = 0; m_dir = 1'b1; m_left = 0;
    end else begin
      case (m_st)
        0: m_st = 1;
        1: begin
          if (req[m_floor]) begin
            m_st = 2; m_left = OPEN_T; m_clr = m_floor;
          end else if ((m_dir && up_pending) || (!m_dir && dn_pending)) begin
            m_st = 3; m_left = RUN_T;
          end else if (up_pending || dn_pending) begin
            m_dir = !m_dir; m_st = 3; m_left = RUN_T;
          end
        end
        2: begin
          fresh = req[m_floor] && (clr_now != m_floor);
          if (door_hold || fresh) begin
            m_left = OPEN_T;
            if (fresh) m_clr = m_floor;
          end else begin
            m_left--;
            if (m_left == 0) m_st = 1;
          end
        end
        3: begin
          m_left--;
          if (m_left == 0) begin
            m_floor = m_dir ? m_floor + 1 : m_floor - 1;
            m_st = 1;
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  // Advance one clock, update the model and the request latch, compare.
  task automatic tick();
    int old_clr;
    @(posedge clk);
    old_clr = m_clr;
    model_step();
    #1;
    if (old_clr >= 0) req[old_clr] = 1'b0;
    check_eq("state", 32'(state), 32'(m_st));
    check_eq("position", 32'(position), 32'd1 << m_floor);
    check_eq("dir", 32'(dir), 32'(m_dir));
    check_eq("opendoor", 32'(opendoor), (m_st == 2) ? 32'd1 : 32'd0);
    check_eq("mv2nxt", 32'(mv2nxt), (m_st == 3) ? 32'd1 : 32'd0);
    check_eq("req_clr", 32'(req_clr), (m_clr >= 0) ? (32'd1 << m_clr) : 32'd0);
    if (opendoor) open_cnt++;
    if (mv2nxt) mv_cnt++;
    if (req_clr != '0) begin
      clr_cnt++;
      clr_seq.push_back(int'(req_clr));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    open_cnt = 0; mv_cnt = 0; clr_cnt = 0;
    clr_seq.delete();
  endtask

  initial begin
    // Reset state.
    rst = 1'b1; enable = 1'b0;
    run(2);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_pos", 32'(position), 32'd1);
    check_eq("rst_dir", 32'(dir), 32'd1);

    // Two floors up to 0100, service there.
    rst = 1'b0; enable = 1'b1; req = 4'b0100;
    clear_counts();
    run(20);
    check_eq("s1_mv_cycles", 32'(mv_cnt), 32'd8);
    check_eq("s1_open_cycles", 32'(open_cnt), 32'd3);
    check_eq("s1_clr_pulses", 32'(clr_cnt), 32'd1);
    check_eq("s1_pos", 32'(position), 32'd4);

    // Request only behind: reverse, descend to 0001, open there.
    req = 4'b0001;
    clear_counts();
    run(20);
    check_eq("s2_dir", 32'(dir), 32'd0);
    check_eq("s2_pos", 32'(position), 32'd1);
    check_eq("s2_open_cycles", 32'(open_cnt), 32'd3);
    check_eq("s2_mv_cycles", 32'(mv_cnt), 32'd8);

    // door_hold on the second open cycle stretches the door to 5 cycles.
    req = 4'b0001;
    clear_counts();
    tick();
    tick();
    door_hold = 1'b1;
    tick();
    door_hold = 1'b0;
    run(10);
    check_eq("s3_open_cycles", 32'(open_cnt), 32'd5);

    // Go to 0010 heading up, then calls at both ends: top first.
    req = 4'b0010;
    run(15);
    check_eq("s4_start_pos", 32'(position), 32'd2);
    check_eq("s4_start_dir", 32'(dir), 32'd1);
    req = 4'b1001;
    clear_counts();
    run(50);
    check_eq("s4_clr_count", 32'(clr_seq.size()), 32'd2);
    if (clr_seq.size() >= 2) begin
      check_eq("s4_first_served", 32'(clr_seq[0]), 32'd8);
      check_eq("s4_second_served", 32'(clr_seq[1]), 32'd1);
    end

    // enable dropped mid-move.
    req = 4'b0100;
    run(3);
    check_eq("s5_moving", 32'(mv2nxt), 32'd1);
    enable = 1'b0;
    tick();
    check_eq("s5_state", 32'(state), 32'd0);
    check_eq("s5_pos", 32'(position), 32'd1);
    check_eq("s5_mv2nxt", 32'(mv2nxt), 32'd0);
    check_eq("s5_opendoor", 32'(opendoor), 32'd0);
    req = '0;
    enable = 1'b1;
    run(2);

    // rst during OPEN.
    req = 4'b0001;
    tick();
    check_eq("s6_open", 32'(opendoor), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("s6_state", 32'(state), 32'd0);
    check_eq("s6_opendoor", 32'(opendoor), 32'd0);
    check_eq("s6_req_clr", 32'(req_clr), 32'd0);
    check_eq("s6_pos", 32'(position), 32'd1);
    rst = 1'b0;
    req = '0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(299) == 0);
      enable    = ($urandom_range(199) != 0);
      door_hold = ($urandom_range(9) == 0);
      if ($urandom_range(7) == 0) req[$urandom_range(NF - 1)] = 1'b1;
      tick();
      check_eq("model_floor_range", (m_floor >= 0 && m_floor < NF) ? 32'd1 : 32'd0, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
